alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller directly upstream of the 4-bit ALU. It holds a 4-entry × 4-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads two operands, drives the ALU's A/B/select/carry-in, captures the ALU result one cycle later and writes it back. It keeps a sticky carry flag so that multi-nibble add/sub chains can be built from successive instructions.

---
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 4-bit ALU: 4x4 register file, one instruction
// in flight, ALU result captured one edge after issue and written back.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    input  logic       instr_use_carry,
    input  logic       ld_valid,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    output logic       alu_cin,
    input  logic [3:0] alu_out,
    input  logic       alu_cout,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic       res_carry,
    output logic       err_div0,
    output logic       carry_flag
);

    // state   | meaning
    // S_IDLE  | waiting for an instruction or a register load
    // S_ISSUE | ALU inputs driven; result captured on leaving this state
    // S_DONE  | result pulse cycle; no new accept
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_rf [4];
    logic [1:0] r_rd;
    logic       r_div0;
    logic       r_arith;
    logic       w_accept;
    logic       w_op_arith;
    logic [3:0] w_rs2_val;

    assign w_accept  = instr_valid && instr_ready;
    assign w_rs2_val = r_rf[instr_rs2];

    // Unmapped selects execute as add in the ALU, so their carry-out is real.
    always_comb begin
        w_op_arith = 1'b0;
        case (instr_op)
            4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1110, 4'b1111: w_op_arith = 1'b1;
            default: w_op_arith = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (r_state == S_IDLE) && !ld_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_rf[i] <= 4'h0;
            r_rd       <= 2'd0;
            r_div0     <= 1'b0;
            r_arith    <= 1'b0;
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            alu_sel    <= 4'h0;
            alu_cin    <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 4'h0;
            res_carry  <= 1'b0;
            err_div0   <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (r_state == S_IDLE && ld_valid) begin
                r_rf[ld_addr] <= ld_data;
            end else if (w_accept) begin
                alu_a   <= r_rf[instr_rs1];
                alu_b   <= w_rs2_val;
                alu_sel <= instr_op;
                alu_cin <= instr_use_carry & carry_flag;
                r_rd    <= instr_rd;
                r_div0  <= (instr_op == 4'b0011) && (w_rs2_val == 4'h0);
                r_arith <= w_op_arith;
            end
            if (r_state == S_ISSUE) begin
                res_valid <= 1'b1;
                err_div0  <= r_div0;
                if (r_div0) begin
                    res_data  <= 4'hF;
                    res_carry <= 1'b0;
                end else begin
                    res_data   <= alu_out;
                    r_rf[r_rd] <= alu_out;
                    if (r_arith) begin
                        res_carry  <= alu_cout;
                        carry_flag <= alu_cout;
                    end else begin
                        res_carry <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl; the bench also plays the 4-bit ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid, instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_use_carry;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic       alu_cin;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_carry, err_div0, carry_flag;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_use_carry(instr_use_carry),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
        .err_div0(err_div0), .carry_flag(carry_flag)
    );

    // Reference ALU; non-arithmetic ops report a stale carry of 1 on purpose.
    function automatic logic [4:0] alu_f(input logic [3:0] sel, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
        logic [4:0] t;
        case (sel)
            4'b0000, 4'b0110, 4'b0111, 4'b1110, 4'b1111:
                t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            4'b0001: t = {1'b0, a} - {1'b0, b} - {4'b0, cin};
            4'b0011: t = (b == 4'h0) ? 5'b1_0000 : {1'b1, a / b};
            4'b1000: t = {1'b1, a & b};
            4'b1001: t = {1'b1, a | b};
            default: t = {1'b1, a ^ b};
        endcase
        return t;
    endfunction

    function automatic bit is_arith(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
    endfunction

    always_comb {alu_cout, alu_out} = alu_f(alu_sel, alu_a, alu_b, alu_cin);

    typedef struct {
        logic [3:0] data;
        logic       carry;
        logic       err;
        logic       flag;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        int         acc_edge;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [3:0] m_rf [4];
    logic       m_flag;
    bit         g_prev_held = 0;
    int         g_prev_edge = 0;
    logic       prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            chk("rv_pulse", {31'd0, prev_rv}, 0);
            if (sb.size() == 0) begin
                chk("rv_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("res_data", {28'd0, res_data}, {28'd0, e.data});
                chk("res_carry", {31'd0, res_carry}, {31'd0, e.carry});
                chk("err_div0", {31'd0, err_div0}, {31'd0, e.err});
                chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.flag});
                chk("alu_a", {28'd0, alu_a}, {28'd0, e.a});
                chk("alu_b", {28'd0, alu_b}, {28'd0, e.b});
                chk("alu_cin", {31'd0, alu_cin}, {31'd0, e.cin});
                chk("latency", cyc, e.acc_edge + 1);
            end
        end
        prev_rv = rst_n && res_valid;
    end

    task automatic wait_idle(output bit ok);
        int k = 0;
        @(negedge clk);
        #1;
        while (!instr_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = instr_ready;
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data, input bit with_instr);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        if (with_instr) begin
            instr_valid = 1'b1;
            instr_op = 4'b1001; instr_rd = addr; instr_rs1 = addr; instr_rs2 = addr;
            instr_use_carry = 1'b0;
        end
        #1;
        chk("rdy_ld", {31'd0, instr_ready}, 0);
        @(posedge clk);
        m_rf[addr] = data;
        @(negedge clk);
        ld_valid = 1'b0;
        if (with_instr) instr_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic uc, input bit hold);
        exp_t       x;
        logic [4:0] r;
        int         k = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_use_carry = uc;
        #1;
        while (!instr_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 1, 0);
            instr_valid = 1'b0;
            return;
        end
        x.a = m_rf[rs1];
        x.b = m_rf[rs2];
        x.cin = uc & m_flag;
        x.acc_edge = cyc + 1;
        r = alu_f(op, x.a, x.b, x.cin);
        if (op == 4'b0011 && x.b == 4'h0) begin
            x.data = 4'hF; x.carry = 1'b0; x.err = 1'b1;
        end else begin
            x.data = r[3:0]; x.err = 1'b0;
            m_rf[rd] = r[3:0];
            if (is_arith(op)) begin
                x.carry = r[4];
                m_flag = r[4];
            end else begin
                x.carry = 1'b0;
            end
        end
        x.flag = m_flag;
        sb.push_back(x);
        if (g_prev_held) chk("acc_gap", x.acc_edge - g_prev_edge, 3);
        g_prev_held = hold;
        g_prev_edge = x.acc_edge;
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic rd_reg(input logic [1:0] r);
        issue(4'b1001, r, r, r, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_op = 4'h0; instr_rd = 2'd0; instr_rs1 = 2'd0;
        instr_rs2 = 2'd0; instr_use_carry = 1'b0;
        ld_valid = 1'b0; ld_addr = 2'd0; ld_data = 4'h0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
        m_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_data", {28'd0, res_data}, 0);
        chk("rst_flag", {31'd0, carry_flag}, 0);
        chk("rst_alu_a", {28'd0, alu_a}, 0);
        chk("rst_ready", {31'd0, instr_ready}, 1);
        rst_n = 1'b1;

        // add with carry chain
        load(2'd0, 4'hF, 0); load(2'd1, 4'h1, 0);
        issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        issue(4'b0000, 2'd3, 2'd2, 2'd2, 1'b1, 0);
        issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        // logic op keeps the flag, then an unmapped select behaves as add
        load(2'd0, 4'hC, 0); load(2'd1, 4'hA, 0);
        issue(4'b1000, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        issue(4'b0110, 2'd3, 2'd0, 2'd1, 1'b1, 0);
        // subtract with borrow out
        load(2'd0, 4'h3, 0); load(2'd1, 4'h5, 0);
        issue(4'b0001, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        // divide by zero, then a legal divide
        load(2'd1, 4'h0, 0); load(2'd2, 4'h5, 0); load(2'd0, 4'h9, 0);
        issue(4'b0011, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        rd_reg(2'd2);
        load(2'd1, 4'h3, 0);
        issue(4'b0011, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        // load wins over a pending instruction, which is not consumed
        load(2'd3, 4'h6, 1);
        rd_reg(2'd3);
        // load outside IDLE is ignored
        issue(4'b1001, 2'd0, 2'd0, 2'd0, 1'b0, 0);
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 4'h7;
        @(posedge clk); @(posedge clk); @(negedge clk);
        ld_valid = 1'b0;
        rd_reg(2'd0);
        // read-after-write stream with instr_valid held high
        load(2'd1, 4'h1, 0);
        issue(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 1);
        issue(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 1);
        issue(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 1);
        issue(4'b0000, 2'd1, 2'd1, 2'd1, 1'b0, 0);
        // reset during ISSUE
        load(2'd0, 4'hF, 0); load(2'd1, 4'h2, 0);
        issue(4'b0000, 2'd2, 2'd0, 2'd1, 1'b0, 0);
        issue(4'b0000, 2'd3, 2'd0, 2'd1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'd0, res_valid}, 0);
        chk("mid_rst_res_data", {28'd0, res_data}, 0);
        chk("mid_rst_res_carry", {31'd0, res_carry}, 0);
        chk("mid_rst_err", {31'd0, err_div0}, 0);
        chk("mid_rst_flag", {31'd0, carry_flag}, 0);
        chk("mid_rst_alu", {19'd0, alu_a, alu_b, alu_sel, alu_cin}, 0);
        void'(sb.pop_back());
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
        m_flag = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", {31'd0, instr_ready}, 1);
        for (int i = 0; i < 4; i++) rd_reg(i[1:0]);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
